gpr_operand_fetch: RTL

//  Read side of the GPR file. Takes decoded uops, drives the regfile read indices, and extracts

---
 rtl/gpr_pkg.sv | 20 ++
 rtl/gpr_merge_extract.sv | 50 +++++
 rtl/gpr_operand_fetch.sv | 119 +++++++++++
 3 files changed

// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - GPR operand width encodings and index legality helper
package gpr_pkg;

  typedef enum logic [2:0] {
    GPR_T_64  = 3'd0,
    GPR_T_32L = 3'd1,
    GPR_T_16L = 3'd2,
    GPR_T_8L  = 3'd3,
    GPR_T_8H  = 3'd4
  } gpr_type_t;

  localparam int GPR_CNT = 16;
  localparam int GPR_W   = 64;

  // The high-byte view only exists for registers 4..7.
  function automatic logic is_8h_legal(input logic [3:0] idx);
    return idx[3:2] == 2'b01;
  endfunction

endpackage

// File: rtl/gpr_merge_extract.sv
// rtl/gpr_merge_extract.sv - overlay a same-cycle writeback on a read value, then extract the operand
module gpr_merge_extract
  import gpr_pkg::*;
(
  input  logic [63:0] base,
  input  logic        wb_en,
  input  logic [3:0]  wb_idx,
  input  logic [2:0]  wb_type,
  input  logic [63:0] wb_val,
  input  logic [3:0]  src_idx,
  input  logic [2:0]  src_type,
  output logic [63:0] operand,
  output logic        err
);

  logic [63:0] merged;

  // Reproduce the regfile write so the operand sees the post-write value.
  always_comb begin
    merged = base;
    if (wb_en && (wb_idx == src_idx)) begin
      case (gpr_type_t'(wb_type))
        GPR_T_64:  merged        = wb_val;
        GPR_T_32L: merged[31:0]  = wb_val[31:0];
        GPR_T_16L: merged[15:0]  = wb_val[15:0];
        GPR_T_8L:  merged[7:0]   = wb_val[7:0];
        GPR_T_8H:  if (is_8h_legal(wb_idx)) merged[15:8] = wb_val[7:0];
        default:   merged        = base;
      endcase
    end
  end

  // Zero-extended extraction; illegal requests yield zero and raise err.
  always_comb begin
    operand = '0;
    err     = 1'b0;
    case (gpr_type_t'(src_type))
      GPR_T_64:  operand = merged;
      GPR_T_32L: operand = {32'd0, merged[31:0]};
      GPR_T_16L: operand = {48'd0, merged[15:0]};
      GPR_T_8L:  operand = {56'd0, merged[7:0]};
      GPR_T_8H: begin
        if (is_8h_legal(src_idx)) operand = {56'd0, merged[15:8]};
        else                      err     = 1'b1;
      end
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/gpr_operand_fetch.sv
// rtl/gpr_operand_fetch.sv - GPR read stage with forwarding, RAW scoreboard and output register
module gpr_operand_fetch
  import gpr_pkg::*;
#(
  parameter int TAG_W    = 8,
  parameter int SB_CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_src1_idx,
  input  logic [2:0]       in_src1_type,
  input  logic [3:0]       in_src2_idx,
  input  logic [2:0]       in_src2_type,
  input  logic             in_dst_wr,
  input  logic [3:0]       in_dst_idx,
  input  logic [TAG_W-1:0] in_tag,
  output logic [3:0]       regOutIdx1,
  output logic [3:0]       regOutIdx2,
  input  logic [63:0]      regOutVal1,
  input  logic [63:0]      regOutVal2,
  input  logic             wb_en,
  input  logic [3:0]       wb_idx,
  input  logic [2:0]       wb_type,
  input  logic [63:0]      wb_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_val1,
  output logic [63:0]      out_val2,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);

  logic [SB_CNT_W-1:0] cnt [GPR_CNT];

  logic [63:0] op1, op2;
  logic        err1, err2;
  logic [SB_CNT_W-1:0] cnt1, cnt2, cntd;
  logic        haz1, haz2, sat, accept;

  assign regOutIdx1 = in_src1_idx;
  assign regOutIdx2 = in_src2_idx;

  gpr_merge_extract u_src1 (
    .base     (regOutVal1),
    .wb_en    (wb_en),
    .wb_idx   (wb_idx),
    .wb_type  (wb_type),
    .wb_val   (wb_val),
    .src_idx  (in_src1_idx),
    .src_type (in_src1_type),
    .operand  (op1),
    .err      (err1)
  );

  gpr_merge_extract u_src2 (
    .base     (regOutVal2),
    .wb_en    (wb_en),
    .wb_idx   (wb_idx),
    .wb_type  (wb_type),
    .wb_val   (wb_val),
    .src_idx  (in_src2_idx),
    .src_type (in_src2_type),
    .operand  (op2),
    .err      (err2)
  );

  // A source whose last pending write lands this cycle is forwarded instead of stalled.
  // Counters are read pre-increment, so a uop never stalls on its own destination.
  always_comb begin
    cnt1   = cnt[in_src1_idx];
    cnt2   = cnt[in_src2_idx];
    cntd   = cnt[in_dst_idx];
    haz1   = (cnt1 != '0) && !((cnt1 == CNT_ONE) && wb_en && (wb_idx == in_src1_idx));
    haz2   = (cnt2 != '0) && !((cnt2 == CNT_ONE) && wb_en && (wb_idx == in_src2_idx));
    sat    = in_dst_wr && (cntd == CNT_MAX) && !(wb_en && (wb_idx == in_dst_idx));
    in_ready = (!out_valid || out_ready) && !haz1 && !haz2 && !sat;
    accept = in_valid && in_ready;
  end

  // Per-register pending-write counters; simultaneous issue and writeback cancel out.
  always_ff @(posedge clk) begin
    for (int r = 0; r < GPR_CNT; r++) begin
      if (reset) begin
        cnt[r] <= '0;
      end else begin
        if (accept && in_dst_wr && (in_dst_idx == r[3:0])) begin
          if (!(wb_en && (wb_idx == r[3:0]))) cnt[r] <= cnt[r] + CNT_ONE;
        end else if (wb_en && (wb_idx == r[3:0]) && (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

  // Output register toward execute: load on accept, hold under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_val1  <= '0;
      out_val2  <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_val1  <= op1;
      out_val2  <= op2;
      out_tag   <= in_tag;
      out_err   <= err1 | err2;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
